int_sequencer: RTL and testbench

Interrupt entry/exit sequencer for the pipelined RAT core. It sits beside the hazard/flush controller and synchronizes and latches the external interrupt line. It waits for the pipeline to reach a clean boundary, then flushes fetch/decode and pushes the return PC through the shared scratch-RAM port. It vectors the PC and tracks the ISR until RETIE/RETID retires, saving and restoring C/Z flags and owning the I (interrupt-enable) flag.

---
 rtl/rat_pkg.sv | 18 +
 rtl/int_sync.sv | 54 +++++
 rtl/int_sequencer.sv | 132 +++++++++++++
 tb/tb_int_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_pkg.sv
// Shared types and defaults for the RAT core interrupt logic.
package rat_pkg;

  localparam int PC_W = 10;
  localparam logic [PC_W-1:0] VEC_ADDR_DEF = 10'h3FF;

  // Interrupt sequencer states. Encodings are fixed so external checkers can
  // decode the state register directly.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_PUSH   = 3'd3,
    ST_VECTOR = 3'd4,
    ST_ISR    = 3'd5
  } IntState;

endpackage

// File: rtl/int_sync.sv
// Two-flop synchronizer for the external interrupt line.
// Build option INT_EDGE_EN: when defined, a rising edge of the synchronized
// line sets a pending latch that is cleared by clr_i (interrupt accepted);
// a new edge in the same cycle as clr_i wins. When undefined, pend_o is the
// synchronized level and clr_i has no effect.
module int_sync (
  input  logic clk,
  input  logic reset,
  input  logic int_req_i,
  input  logic clr_i,
  output logic pend_o
);

  logic sync1_q;
  logic sync2_q;

  // Metastability filter: the line is only used after the second flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= int_req_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef INT_EDGE_EN
  logic sync3_q;
  logic latch_q;
  logic rise;

  assign rise = sync2_q & ~sync3_q;

  // Edge history and pending latch; set beats clear, repeated edges merge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync3_q <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      sync3_q <= sync2_q;
      latch_q <= rise | (latch_q & ~clr_i);
    end
  end

  // The edge itself counts as pending so latency matches the level build.
  assign pend_o = latch_q | rise;
`else
  logic unused_clr;
  assign unused_clr = clr_i;
  assign pend_o     = sync2_q;
`endif

endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: waits for a clean pipeline boundary,
// flushes fetch/decode, pushes the return PC through the scratch-RAM port,
// vectors the PC and tracks the ISR until RETIE/RETID retires.
// Build option INT_EDGE_EN selects edge-latched (defined) or level-sensitive
// (undefined, default) interrupt pending; see int_sync.
module int_sequencer
  import rat_pkg::*;
#(
  parameter int                PC_W     = rat_pkg::PC_W,
  parameter logic [PC_W-1:0]   VEC_ADDR = rat_pkg::VEC_ADDR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            int_req,
  input  logic            int_en_set,
  input  logic            int_en_clr,
  input  logic            ret_int,
  input  logic            ret_int_ie,
  input  logic            pipe_busy,
  input  logic [PC_W-1:0] retire_pc,
  input  logic            flag_c,
  input  logic            flag_z,
  input  logic            push_gnt,
  output logic            push_req,
  output logic [PC_W-1:0] push_data,
  output logic            flush,
  output logic            pc_load_vec,
  output logic [PC_W-1:0] vec_addr,
  output logic            int_ack,
  output logic            int_en,
  output logic            in_isr,
  output logic            flags_restore,
  output logic            shadow_c,
  output logic            shadow_z
);

  IntState         state_q, state_d;
  logic            int_en_q, int_en_d;
  logic [PC_W-1:0] push_data_q, push_data_d;
  logic            shadow_c_q, shadow_c_d;
  logic            shadow_z_q, shadow_z_d;
  logic            pend;

  int_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .int_req_i (int_req),
    .clr_i     (int_ack),
    .pend_o    (pend)
  );

  // Sequencer next state: entry only from IDLE, so the ISR never nests.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pend && int_en_q && !int_en_clr) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (int_en_clr)      state_d = ST_IDLE;
        else if (!pipe_busy) state_d = ST_FLUSH;
      end
      ST_FLUSH:  state_d = ST_PUSH;
      ST_PUSH:   if (push_gnt) state_d = ST_VECTOR;
      ST_VECTOR: state_d = ST_ISR;
      ST_ISR:    if (ret_int) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // I flag: software writes except during the committed entry window;
  // clear beats set; return from ISR loads it from RETIE/RETID.
  always_comb begin
    int_en_d = int_en_q;
    case (state_q)
      ST_FLUSH:            int_en_d = 1'b0;
      ST_PUSH, ST_VECTOR:  int_en_d = int_en_q;
      ST_ISR: begin
        if (ret_int)         int_en_d = ret_int_ie;
        else if (int_en_clr) int_en_d = 1'b0;
        else if (int_en_set) int_en_d = 1'b1;
      end
      default: begin
        if (int_en_clr)      int_en_d = 1'b0;
        else if (int_en_set) int_en_d = 1'b1;
      end
    endcase
  end

  // Return PC and flag shadows are captured once, at the flush boundary.
  always_comb begin
    push_data_d = push_data_q;
    shadow_c_d  = shadow_c_q;
    shadow_z_d  = shadow_z_q;
    if (state_q == ST_FLUSH) begin
      push_data_d = retire_pc;
      shadow_c_d  = flag_c;
      shadow_z_d  = flag_z;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      int_en_q    <= 1'b0;
      push_data_q <= '0;
      shadow_c_q  <= 1'b0;
      shadow_z_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      int_en_q    <= int_en_d;
      push_data_q <= push_data_d;
      shadow_c_q  <= shadow_c_d;
      shadow_z_q  <= shadow_z_d;
    end
  end

  // Moore strobes decoded from state; flags_restore follows ret_int in ISR.
  // Push handshake: push_req stays high with push_data stable until the
  // cycle push_gnt is sampled high; that cycle completes the transfer.
  assign flush         = (state_q == ST_FLUSH);
  assign push_req      = (state_q == ST_PUSH);
  assign pc_load_vec   = (state_q == ST_VECTOR);
  assign int_ack       = (state_q == ST_VECTOR);
  assign in_isr        = (state_q == ST_ISR);
  assign flags_restore = (state_q == ST_ISR) && ret_int;
  assign push_data     = push_data_q;
  assign int_en        = int_en_q;
  assign shadow_c      = shadow_c_q;
  assign shadow_z      = shadow_z_q;
  assign vec_addr      = VEC_ADDR;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer with a vector-event scoreboard.
module tb_int_sequencer;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         int_req = 1'b0;
  logic         int_en_set = 1'b0;
  logic         int_en_clr = 1'b0;
  logic         ret_int = 1'b0;
  logic         ret_int_ie = 1'b0;
  logic         pipe_busy = 1'b0;
  logic [W-1:0] retire_pc = '0;
  logic         flag_c = 1'b0;
  logic         flag_z = 1'b0;
  logic         push_gnt = 1'b1;
  logic         push_req;
  logic [W-1:0] push_data;
  logic         flush;
  logic         pc_load_vec;
  logic [W-1:0] vec_addr;
  logic         int_ack;
  logic         int_en;
  logic         in_isr;
  logic         flags_restore;
  logic         shadow_c;
  logic         shadow_z;

  int_sequencer #(.PC_W(W), .VEC_ADDR(10'h3FF)) dut (
    .clk(clk), .reset(reset), .int_req(int_req),
    .int_en_set(int_en_set), .int_en_clr(int_en_clr),
    .ret_int(ret_int), .ret_int_ie(ret_int_ie), .pipe_busy(pipe_busy),
    .retire_pc(retire_pc), .flag_c(flag_c), .flag_z(flag_z),
    .push_gnt(push_gnt), .push_req(push_req), .push_data(push_data),
    .flush(flush), .pc_load_vec(pc_load_vec), .vec_addr(vec_addr),
    .int_ack(int_ack), .int_en(int_en), .in_isr(in_isr),
    .flags_restore(flags_restore), .shadow_c(shadow_c), .shadow_z(shadow_z)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           flush_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every vector event must match the next expected entry.
  logic         prev_req = 1'b0;
  logic [W-1:0] prev_data = '0;
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    int           c;
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (flush) flush_cnt++;
      if (pc_load_vec) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_vector: got pc_load_vec=1 at cycle %0d, required 0", cyc);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          chk("vec_push_data", push_data, e);
          chk("vec_cycle", cyc, c);
          chk("vec_int_ack", int_ack, 1'b1);
          chk("vec_addr", vec_addr, 10'h3FF);
        end
      end
      if (push_req && prev_req) chk("push_data_stable", push_data, prev_data);
      prev_req  = push_req;
      prev_data = push_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    int_req = 1'b0; int_en_set = 1'b0; int_en_clr = 1'b0;
    ret_int = 1'b0; ret_int_ie = 1'b0; pipe_busy = 1'b0; push_gnt = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic set_int_en();
    tick();
    int_en_set = 1'b1;
    tick();
    int_en_set = 1'b0;
  endtask

  task automatic wait_isr(input string name);
    int n = 0;
    while (!in_isr && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (!in_isr) begin
      bad++;
      $display("FAIL %s: got in_isr=0 after 40 cycles, required 1", name);
    end
  endtask

  task automatic do_ret(input logic ie);
    tick();
    ret_int = 1'b1;
    ret_int_ie = ie;
    @(negedge clk);
    chk("flags_restore_on_ret", flags_restore, 1'b1);
    tick();
    ret_int = 1'b0;
    chk("isr_exit", in_isr, 1'b0);
    chk("int_en_after_ret", int_en, ie);
    chk("flags_restore_drop", flags_restore, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int k;
    int f0;
    int n;

    // Reset state
    apply_reset();
    tick();
    chk("rst_push_req", push_req, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_pc_load_vec", pc_load_vec, 1'b0);
    chk("rst_int_ack", int_ack, 1'b0);
    chk("rst_in_isr", in_isr, 1'b0);
    chk("rst_int_en", int_en, 1'b0);
    chk("rst_shadow_c", shadow_c, 1'b0);
    chk("rst_shadow_z", shadow_z, 1'b0);
    chk("rst_push_data", push_data, 10'h000);
    chk("rst_vec_addr", vec_addr, 10'h3FF);

    // Minimum-latency entry, RETIE exit
    set_int_en();
    chk("int_en_set", int_en, 1'b1);
    retire_pc = 10'h042; flag_c = 1'b1; flag_z = 1'b0;
    tick();
    int_req = 1'b1;
    exp_q.push_back(10'h042); exp_cyc_q.push_back(cyc + 6);
    wait_isr("isr_min");
    chk("int_en_cleared_in_isr", int_en, 1'b0);
    chk("shadow_c_cap", shadow_c, 1'b1);
    chk("shadow_z_cap", shadow_z, 1'b0);
    chk("push_data_cap", push_data, 10'h042);
    int_req = 1'b0;
    repeat (4) tick();
    flag_c = 1'b0; flag_z = 1'b1;
    do_ret(1'b1);
    chk("shadow_c_hold", shadow_c, 1'b1);
    chk("shadow_z_hold", shadow_z, 1'b0);

    // pipe_busy 3 cycles in DRAIN, push_gnt low 2 cycles in PUSH, RETID exit
    retire_pc = 10'h155; flag_c = 1'b0; flag_z = 1'b1;
    tick();
    k = cyc;
    int_req = 1'b1; pipe_busy = 1'b1; push_gnt = 1'b0;
    exp_q.push_back(10'h155); exp_cyc_q.push_back(k + 11);
    while (cyc < k + 10) begin
      tick();
      if (cyc == k + 6) pipe_busy = 1'b0;
      if (cyc == k + 8) retire_pc = 10'h2AA;
      if (cyc == k + 10) push_gnt = 1'b1;
    end
    wait_isr("isr_delayed");
    chk("shadow_c_cap2", shadow_c, 1'b0);
    chk("shadow_z_cap2", shadow_z, 1'b1);
    int_req = 1'b0;
    repeat (4) tick();
    do_ret(1'b0);

    // Abort from DRAIN via CLI, then simultaneous SEI+CLI
    apply_reset();
    set_int_en();
    tick();
    k = cyc;
    f0 = flush_cnt;
    int_req = 1'b1; pipe_busy = 1'b1;
    while (cyc < k + 4) tick();
    int_en_clr = 1'b1;
    tick();
    int_en_clr = 1'b0;
    chk("abort_int_en", int_en, 1'b0);
    int_req = 1'b0; pipe_busy = 1'b0;
    repeat (8) tick();
    chk("abort_no_flush", flush_cnt, f0);
    chk("abort_idle", in_isr, 1'b0);
    tick();
    int_en_set = 1'b1; int_en_clr = 1'b1;
    tick();
    int_en_set = 1'b0; int_en_clr = 1'b0;
    chk("set_clr_clr_wins", int_en, 1'b0);

    // Reset while push_req is high, then a clean minimum-latency entry
    apply_reset();
    set_int_en();
    push_gnt = 1'b0; retire_pc = 10'h0AB;
    tick();
    int_req = 1'b1;
    n = 0;
    while (!push_req && n < 20) begin
      tick();
      n++;
    end
    chk("push_req_reached", push_req, 1'b1);
    reset = 1'b1;
    tick();
    chk("rst_push_req_drop", push_req, 1'b0);
    chk("rst_push_int_en", int_en, 1'b0);
    chk("rst_push_in_isr", in_isr, 1'b0);
    chk("rst_push_data_clr", push_data, 10'h000);
    reset = 1'b0; int_req = 1'b0; push_gnt = 1'b1;
    repeat (3) tick();
    set_int_en();
    retire_pc = 10'h1C3;
    tick();
    int_req = 1'b1;
    exp_q.push_back(10'h1C3); exp_cyc_q.push_back(cyc + 6);
    wait_isr("isr_after_reset");
    int_req = 1'b0;
    repeat (4) tick();
    do_ret(1'b0);

`ifdef INT_EDGE_EN
    // Two edges during ISR merge into one re-entry after RETIE
    apply_reset();
    set_int_en();
    retire_pc = 10'h2F0;
    tick();
    int_req = 1'b1;
    exp_q.push_back(10'h2F0); exp_cyc_q.push_back(cyc + 6);
    wait_isr("isr_edge");
    int_req = 1'b0;
    repeat (3) tick();
    repeat (2) begin
      int_req = 1'b1;
      repeat (3) tick();
      int_req = 1'b0;
      repeat (3) tick();
    end
    exp_q.push_back(10'h2F0); exp_cyc_q.push_back(cyc + 1 + 5);
    do_ret(1'b1);
    wait_isr("isr_edge_reentry");
    repeat (2) tick();
    do_ret(1'b0);
    repeat (15) tick();
    chk("edge_single_reentry", in_isr, 1'b0);
`else
    // Line dropped before exit: no re-entry
    apply_reset();
    set_int_en();
    retire_pc = 10'h2F0;
    tick();
    int_req = 1'b1;
    exp_q.push_back(10'h2F0); exp_cyc_q.push_back(cyc + 6);
    wait_isr("isr_level");
    int_req = 1'b0;
    repeat (4) tick();
    do_ret(1'b1);
    repeat (15) tick();
    chk("level_no_reentry", in_isr, 1'b0);
    // Line still high at RETIE: immediate re-entry
    retire_pc = 10'h0F5;
    tick();
    int_req = 1'b1;
    exp_q.push_back(10'h0F5); exp_cyc_q.push_back(cyc + 6);
    wait_isr("isr_level_held");
    exp_q.push_back(10'h0F5); exp_cyc_q.push_back(cyc + 1 + 5);
    do_ret(1'b1);
    wait_isr("isr_level_reentry");
    int_req = 1'b0;
    repeat (4) tick();
    do_ret(1'b0);
`endif

    // Final report
    repeat (3) tick();
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
